// File: rtl/i2c_pkg.sv
// Purpose: shared I2C definitions for the register-write initiator and the register target.
// Latency: none (types, constants and a pure decode function).
// Backpressure: not applicable.
package i2c_pkg;

   // Controller states, one per bus slot kind plus the idle and done bookends.
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BIT,
      S_ACK,
      S_STOP,
      S_DONE
   } state_t;

   // Bus level driven by the receiver in the ninth clock of a byte.
   localparam logic ACK      = 1'b0;
   localparam logic NACK     = 1'b1;

   // R/W bit appended to the 7-bit address.
   localparam logic RW_WRITE = 1'b0;

   // Quarter index inside a slot (q0..q3).
   typedef logic [1:0] quarter_t;

   // Open-drain pull-down enables for the two bus lines.
   typedef struct packed {
      logic scl_oe;
      logic sda_oe;
   } line_t;

   // Line pattern for a given slot kind and quarter. bit_val is the data bit
   // of the current BIT slot and is ignored elsewhere.
   function automatic line_t line_drive(input state_t st, input quarter_t q, input logic bit_val);
      line_t d;
      d = '0;
      case (st)
         S_START: begin
            d.scl_oe = (q == 2'd3);
            d.sda_oe = (q != 2'd0);
         end
         S_BIT: begin
            d.scl_oe = ~q[1];
            d.sda_oe = ~bit_val;
         end
         S_ACK: begin
            d.scl_oe = ~q[1];
            d.sda_oe = 1'b0;
         end
         S_STOP: begin
            d.scl_oe = (q == 2'd0);
            d.sda_oe = ~q[1];
         end
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Purpose: prescaler emitting a one-cycle tick every QUARTER_DIV clocks.
// Latency: first tick QUARTER_DIV-1 cycles after restart is released.
// Backpressure: none; restart holds the count at zero and suppresses the tick.
module i2c_quarter_tick #(
   parameter int unsigned QUARTER_DIV = 25
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned CW = (QUARTER_DIV > 2) ? $clog2(QUARTER_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(QUARTER_DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running modulo-QUARTER_DIV counter, forced to zero while restart is high.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else if (restart_i || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick_o = (cnt == LAST) && !restart_i;

endmodule

// File: rtl/i2c_reg_writer.sv
// Purpose: I2C master issuing single register writes (START, addr+W, reg, data, STOP).
// Latency: done pulse 116*QUARTER_DIV clocks after acceptance (44 / 80 on address / register NACK).
// Backpressure: cmd_ready_o high only in IDLE; command fields latched on acceptance.
module i2c_reg_writer #(
   parameter int unsigned QUARTER_DIV = 25
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [6:0] cmd_addr_i,
   input  logic [7:0] cmd_reg_i,
   input  logic [7:0] cmd_data_i,
   output logic       done_o,
   output logic       nack_o,
   output logic       scl_oe_o,
   output logic       sda_oe_o,
   input  logic       sda_i
);

   import i2c_pkg::*;

   state_t     state_q, state_n;
   quarter_t   quarter_q, quarter_n;
   logic [2:0] bit_cnt_q, bit_cnt_n;
   logic [1:0] byte_cnt_q, byte_cnt_n;
   logic       nack_q, nack_n;
   logic [6:0] addr_q, addr_n;
   logic [7:0] reg_q, reg_n;
   logic [7:0] data_q, data_n;

   logic       tick;
   logic       restart;
   logic [7:0] tx_byte_n;
   line_t      drive_n;

   logic       scl_oe_q, sda_oe_q, done_q, nack_out_q;

   // The quarter grid is re-aligned to the acceptance edge by holding the
   // prescaler in restart for as long as the controller sits in IDLE.
   assign restart = (state_q == S_IDLE);

   i2c_quarter_tick #(
      .QUARTER_DIV(QUARTER_DIV)
   ) u_tick (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .restart_i (restart),
      .tick_o    (tick)
   );

   // Next-state logic: command capture, slot sequencing, bit/byte counting and ACK sampling.
   always_comb begin
      state_n    = state_q;
      quarter_n  = quarter_q;
      bit_cnt_n  = bit_cnt_q;
      byte_cnt_n = byte_cnt_q;
      nack_n     = nack_q;
      addr_n     = addr_q;
      reg_n      = reg_q;
      data_n     = data_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               addr_n     = cmd_addr_i;
               reg_n      = cmd_reg_i;
               data_n     = cmd_data_i;
               nack_n     = 1'b0;
               bit_cnt_n  = 3'd7;
               byte_cnt_n = 2'd0;
               quarter_n  = 2'd0;
               state_n    = S_START;
            end
         end
         S_START, S_BIT, S_ACK, S_STOP: begin
            if (tick) begin
               quarter_n = quarter_q + 2'd1;
               if (quarter_q == 2'd3) begin
                  case (state_q)
                     S_START: begin
                        byte_cnt_n = 2'd0;
                        bit_cnt_n  = 3'd7;
                        state_n    = S_BIT;
                     end
                     S_BIT: begin
                        if (bit_cnt_q == 3'd0) begin
                           state_n = S_ACK;
                        end else begin
                           bit_cnt_n = bit_cnt_q - 3'd1;
                        end
                     end
                     S_ACK: begin
                        // A NACK on any byte ends the write with a STOP.
                        if (sda_i == NACK) begin
                           nack_n  = 1'b1;
                           state_n = S_STOP;
                        end else if (byte_cnt_q == 2'd2) begin
                           state_n = S_STOP;
                        end else begin
                           byte_cnt_n = byte_cnt_q + 2'd1;
                           bit_cnt_n  = 3'd7;
                           state_n    = S_BIT;
                        end
                     end
                     default: state_n = S_DONE;
                  endcase
               end
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Byte on the wire for the upcoming cycle, selected by the byte counter.
   always_comb begin
      tx_byte_n = {addr_n, RW_WRITE};
      case (byte_cnt_n)
         2'd1:    tx_byte_n = reg_n;
         2'd2:    tx_byte_n = data_n;
         default: tx_byte_n = {addr_n, RW_WRITE};
      endcase
      drive_n = line_drive(state_n, quarter_n, tx_byte_n[bit_cnt_n]);
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         quarter_q  <= 2'd0;
         bit_cnt_q  <= 3'd7;
         byte_cnt_q <= 2'd0;
         nack_q     <= 1'b0;
         addr_q     <= '0;
         reg_q      <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_n;
         quarter_q  <= quarter_n;
         bit_cnt_q  <= bit_cnt_n;
         byte_cnt_q <= byte_cnt_n;
         nack_q     <= nack_n;
         addr_q     <= addr_n;
         reg_q      <= reg_n;
         data_q     <= data_n;
      end
   end

   // Registered pad enables and status so the open-drain drivers never see
   // decode glitches; reset releases both lines immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_oe_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
         done_q     <= 1'b0;
         nack_out_q <= 1'b0;
      end else begin
         scl_oe_q   <= drive_n.scl_oe;
         sda_oe_q   <= drive_n.sda_oe;
         done_q     <= (state_n == S_DONE);
         nack_out_q <= (state_n == S_DONE) && nack_n;
      end
   end

   assign cmd_ready_o = (state_q == S_IDLE);
   assign done_o      = done_q;
   assign nack_o      = nack_out_q;
   assign scl_oe_o    = scl_oe_q;
   assign sda_oe_o    = sda_oe_q;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Purpose: directed bench for i2c_reg_writer with a behavioural register target on the bus.
// Latency: checks done_o timing against slot counts derived from bytes sent.
// Backpressure: exercises held cmd_valid_i and back-to-back acceptance.
module tb_i2c_reg_writer;

   localparam int QD = 4;
   localparam int TOK_START = 256;
   localparam int TOK_STOP  = 257;

   typedef struct {
      logic nack;
      int   lat;
   } done_exp_t;

   logic       clk = 1'b0;
   bit         clk_run = 1'b0;
   logic       rst_ni;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_reg;
   logic [7:0] cmd_data;
   logic       done;
   logic       nack;
   logic       scl_oe;
   logic       sda_oe;
   logic       tgt_oe = 1'b0;
   logic       sda_line;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Scoreboards: bus tokens and done events expected, in order.
   int        exp_tok[$];
   done_exp_t exp_done[$];

   // Target model state.
   logic [6:0] tgt_addr = 7'h40;
   int         nack_byte = -1;
   logic [7:0] blob [256];
   bit         mon_en = 1'b1;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   bit         active = 1'b0, acking = 1'b0, addressed = 1'b0;
   int         bitcnt = 0, byteidx = 0;
   logic [7:0] sh = '0, rptr = '0;
   int         stop_cyc = -1;

   // Monitor state.
   logic prev_ready = 1'b1;
   int   acc_cyc = -1;
   int   last_done_cyc = -1;
   bit   b2b_pend = 1'b0;

   assign sda_line = ~(sda_oe | tgt_oe);

   i2c_reg_writer #(.QUARTER_DIV(QD)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_addr_i  (cmd_addr),
      .cmd_reg_i   (cmd_reg),
      .cmd_data_i  (cmd_data),
      .done_o      (done),
      .nack_o      (nack),
      .scl_oe_o    (scl_oe),
      .sda_oe_o    (sda_oe),
      .sda_i       (sda_line)
   );

   always #5 if (clk_run) clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic token(input int t);
      if (mon_en) begin
         if (exp_tok.size() == 0) chk("bus_extra_token", t, 32'h0000_0FFF);
         else                     chk("bus_token", t, exp_tok.pop_front());
      end
   endtask

   // Bus decoder and register target: START/STOP detection, bit shifting on
   // SCL rise, ACK driven for the ninth clock, register written on data ACK.
   always @(negedge clk) begin
      logic scl_s, sda_s, ack;
      scl_s = ~scl_oe;
      sda_s = sda_line;
      if (prev_scl && scl_s && prev_sda && !sda_s) begin
         if (mon_en && stop_cyc >= 0) chk("bus_free_time", int'(cyc - stop_cyc >= QD), 1);
         active = 1; bitcnt = 0; byteidx = 0; acking = 0; addressed = 0; tgt_oe = 1'b0;
         token(TOK_START);
      end else if (prev_scl && scl_s && !prev_sda && sda_s) begin
         active = 0; acking = 0; tgt_oe = 1'b0;
         stop_cyc = cyc;
         token(TOK_STOP);
      end else if (active && !prev_scl && scl_s) begin
         if (bitcnt < 8) begin
            sh = {sh[6:0], sda_s};
            bitcnt++;
         end
      end else if (active && prev_scl && !scl_s) begin
         if (acking) begin
            tgt_oe = 1'b0; acking = 0; bitcnt = 0; byteidx++;
         end else if (bitcnt == 8) begin
            token(int'(sh));
            if (byteidx == 0) begin
               addressed = (sh[7:1] == tgt_addr) && (sh[0] == 1'b0);
               ack = addressed;
            end else begin
               ack = addressed && (byteidx != nack_byte);
            end
            if (ack && byteidx == 1) rptr = sh;
            if (ack && byteidx == 2) blob[rptr] = sh;
            tgt_oe = ack;
            acking = 1;
         end
      end
      prev_scl = scl_s;
      prev_sda = sda_s;
   end

   // Acceptance/done monitor: latency, NACK status and back-to-back spacing.
   always @(negedge clk) begin
      if (rst_ni) begin
         if (prev_ready && !cmd_ready) begin
            acc_cyc = cyc;
            if (b2b_pend) begin
               chk("b2b_accept_edge", acc_cyc, last_done_cyc + 2);
               b2b_pend = 0;
            end
         end
         if (done) begin
            done_exp_t e;
            last_done_cyc = cyc;
            chk("done_expected", int'(exp_done.size() != 0), 1);
            if (exp_done.size() != 0) begin
               e = exp_done.pop_front();
               chk("done_latency", cyc - acc_cyc, e.lat);
               chk("done_nack", nack, e.nack);
            end
         end else begin
            chk("nack_without_done", nack, 1'b0);
         end
      end
      prev_ready = cmd_ready;
   end

   // Drive a command and record what the target should see and report.
   task automatic issue(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d, input bit hold);
      logic [7:0] bytes [3];
      bit aok, nk;
      int nb;
      bytes[0] = {a, 1'b0};
      bytes[1] = r;
      bytes[2] = d;
      aok = (a == tgt_addr);
      nb  = !aok ? 1 : ((nack_byte == 1) ? 2 : 3);
      nk  = !aok || (nack_byte == 1) || (nack_byte == 2);
      exp_tok.push_back(TOK_START);
      for (int i = 0; i < nb; i++) exp_tok.push_back(int'(bytes[i]));
      exp_tok.push_back(TOK_STOP);
      exp_done.push_back('{nk, (2 + 9 * nb) * 4 * QD});
      cmd_addr  = a;
      cmd_reg   = r;
      cmd_data  = d;
      cmd_valid = 1'b1;
      for (int i = 0; i < 3000 && !cmd_ready; i++) @(negedge clk);
      chk("accept_timeout", cmd_ready, 1'b1);
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000 && exp_done.size() != 0; i++) @(negedge clk);
      chk("done_timeout", exp_done.size(), 0);
      chk("bus_tokens_left", exp_tok.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) blob[i] = 8'h00;
      rst_ni    = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_reg   = '0;
      cmd_data  = '0;

      // Reset values with no clock running.
      #20;
      chk("rst_scl_oe", scl_oe, 1'b0);
      chk("rst_sda_oe", sda_oe, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_nack", nack, 1'b0);

      clk_run = 1'b1;
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk);

      // Full write, all bytes ACKed.
      issue(7'h40, 8'h06, 8'h99, 1'b0);
      wait_done();
      chk("full_write_reg", blob[8'h06], 8'h99);

      // Address NACK: target answers only 0x41.
      tgt_addr = 7'h41;
      issue(7'h40, 8'h07, 8'h55, 1'b0);
      wait_done();
      chk("addr_nack_no_write", blob[8'h07], 8'h00);
      tgt_addr = 7'h40;

      // Register-byte NACK.
      nack_byte = 1;
      issue(7'h40, 8'h08, 8'h66, 1'b0);
      wait_done();
      chk("reg_nack_no_write", blob[8'h08], 8'h00);

      // Data-byte NACK.
      nack_byte = 2;
      issue(7'h40, 8'h20, 8'hA5, 1'b0);
      wait_done();
      chk("data_nack_no_write", blob[8'h20], 8'h00);
      nack_byte = -1;

      // Back-to-back with valid held and fields changing mid-transaction.
      issue(7'h40, 8'h12, 8'h34, 1'b1);
      @(negedge clk);
      b2b_pend = 1'b1;
      issue(7'h40, 8'h56, 8'h78, 1'b1);
      cmd_addr  = 7'h33;
      cmd_reg   = 8'hAA;
      cmd_data  = 8'hBB;
      cmd_valid = 1'b0;
      wait_done();
      chk("b2b_first_reg", blob[8'h12], 8'h34);
      chk("b2b_second_reg", blob[8'h56], 8'h78);
      chk("b2b_no_stray_write", blob[8'hAA], 8'h00);
      chk("b2b_flag_consumed", b2b_pend, 1'b0);

      // Loopback write to the top register.
      issue(7'h40, 8'hFE, 8'h1E, 1'b0);
      wait_done();
      chk("loopback_reg_fe", blob[8'hFE], 8'h1E);

      // Reset pulsed during the data byte: lines released at once, no write.
      issue(7'h40, 8'hFE, 8'h77, 1'b0);
      for (int i = 0; i < 3000 && !(byteidx == 2 && bitcnt == 4); i++) @(negedge clk);
      chk("reach_data_byte", int'(byteidx == 2 && bitcnt == 4), 1);
      mon_en = 1'b0;
      exp_tok.delete();
      exp_done.delete();
      #2;
      rst_ni = 1'b0;
      #1;
      chk("midrst_scl_oe", scl_oe, 1'b0);
      chk("midrst_sda_oe", sda_oe, 1'b0);
      chk("midrst_cmd_ready", cmd_ready, 1'b1);
      repeat (5) @(negedge clk);
      rst_ni = 1'b1;
      repeat (40 * QD) @(negedge clk);
      chk("midrst_no_write", blob[8'hFE], 8'h1E);
      chk("midrst_idle_scl", scl_oe, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_reg_writer.md
# i2c_reg_writer

I2C controller that performs single-register write transactions (START, address+W, register id, data byte, STOP) against an I2C target such as our PWM register target. It is the initiator for the target-side register interface. It is used as the host-side stimulus engine in loopback builds and as the bus master on boards that configure a PWM target from on-chip logic. Commands arrive over a valid/ready handshake, and completion is reported with a one-cycle done pulse carrying ACK/NACK status.

## Interface
- QUARTER_DIV, default 25: clk_i cycles per quarter SCL bit period; 25 gives 100 kHz SCL at 10 MHz clk_i; legal range 2..65535.
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid & ready on a rising clk_i edge.
- cmd_addr_i  in  7  target 7-bit address.
- cmd_reg_i  in  8  register id.
- cmd_data_i  in  8  register value.
- done_o  out  1  one-cycle pulse at transaction end.
- nack_o  out  1  valid with done_o; 1 means some byte was NACKed.
- scl_oe_o  out  1  1 pulls SCL low, 0 releases it (open drain at the pad).
- sda_oe_o  out  1  1 pulls SDA low, 0 releases it.
- sda_i  in  1  sampled SDA pad level, already synchronized externally.

## Operation
- The controller is a single master: no arbitration and no clock-stretch detection.
- Command fields are latched on acceptance. cmd_ready_o is 1 only in IDLE.
- The transaction is built from slots of 4 quarters each (q0..q3). Every quarter lasts QUARTER_DIV clocks, counted by a prescaler that restarts at acceptance.
- The bytes sent are {addr, 1'b0}, then reg, then data, each MSB first.
- States: IDLE, START, BIT, ACK, STOP, DONE.
- IDLE: both lines released. On acceptance, go to START.
- START slot:
  - q0: SCL and SDA released.
  - q1 and q2: SDA low.
  - q3: SCL low.
  - Then go to BIT with byte 0, bit 7.
- BIT slot:
  - q0: SCL low; sda_oe_o = ~bit.
  - q1: SCL low.
  - q2 and q3: SCL released.
  - After bit 0, go to ACK.
- ACK slot:
  - SDA released for the whole slot; SCL follows the same pattern as a BIT slot.
  - sda_i is sampled on the last clock of q3. 0 means ACK, 1 means NACK.
  - On ACK for byte 0 or 1, go to BIT for the next byte.
  - On ACK for byte 2, or on any NACK, go to STOP. A NACK also sets a sticky nack flag.
- STOP slot:
  - q0: SCL low, SDA low.
  - q1: SCL released.
  - q2 and q3: SDA released.
  - Then go to DONE.
- DONE (1 clock): done_o = 1 and nack_o = nack flag. Then go to IDLE with cmd_ready_o = 1.
- NACK on the address or register byte aborts the transaction: no further bytes are sent.

## Timing
- Reset values: scl_oe_o = 0, sda_oe_o = 0, cmd_ready_o = 1, done_o = 0, nack_o = 0, state IDLE.
- Reset asserted mid-transaction releases both lines asynchronously in the same instant. No STOP is generated.
- Latency from the acceptance edge to done_o high:
  - full transaction: 29 slots × 4 × QUARTER_DIV clocks (116·QUARTER_DIV);
  - NACK on address: 11 slots (44·QUARTER_DIV);
  - NACK on register: 20 slots (80·QUARTER_DIV).
- SDA changes only in q0, while SCL is low. The exceptions are START and STOP edges, which occur while SCL is released.
- Back-to-back commands: a new command can be accepted on the clock after done_o. Its START q0 provides at least one quarter of bus-free time.
- cmd_valid_i and the cmd fields are ignored outside IDLE.
- nack_o is 0 whenever done_o is 0.

## Structure
- Shared package i2c_pkg holds:
  - the state enum;
  - ACK = 1'b0 and NACK = 1'b1;
  - RW_WRITE = 1'b0;
  - the slot phase type (2-bit quarter index).
- The target block uses the same package constants.
- Sub-module i2c_quarter_tick: a prescaler producing a one-cycle tick every QUARTER_DIV clocks, with a synchronous restart input. The controller FSM, bit counter (3 bits) and byte counter (2 bits) stay in i2c_reg_writer.

## Test plan
- Reset: with rst_ni low and no clock, outputs are scl_oe_o = 0, sda_oe_o = 0, cmd_ready_o = 1, done_o = 0, nack_o = 0.
- Full write with QUARTER_DIV = 4, addr 0x40, reg 0x06, data 0x99, and a target model that ACKs:
  - bus decoder sees START, 0x80, 0x06, 0x99, STOP;
  - done_o arrives 464 clocks after acceptance, with nack_o = 0.
- Address NACK (target answers only 0x41, command addr 0x40, QUARTER_DIV = 4):
  - only byte 0x80 appears on the bus, followed by STOP;
  - done_o arrives at 176 clocks, with nack_o = 1.
- Data-byte NACK (target NACKs the third byte): all three bytes appear, done_o arrives at 464 clocks, nack_o = 1.
- Back-to-back:
  - cmd_valid_i held high with two commands;
  - the second is accepted on the clock after done_o;
  - SCL/SDA show STOP, at least QUARTER_DIV clocks idle, then START;
  - cmd fields changed mid-transaction do not alter the bytes on the bus.
- Loopback against our I2C target (address_i = 6'h00, so assigned address 0x40; QUARTER_DIV = 25), write reg 0xFE value 0x1E: the target's register blob byte 0xFE reads 0x1E and nack_o = 0. Repeat with rst_ni pulsed low during the data byte: both lines are released immediately and no register is written.
